// File: rtl/blend_frame_writer.sv
// ============================================================================
//  Module      : blend_frame_writer
//  Description : Alpha-blends camera and warped-source RGB565 pixels, buffers
//                results in a small FIFO and writes them to frame-buffer SRAM
//                over a req/ack handshake. Optional macro: CHROMA_KEY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module blend_frame_writer #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] KEY_COLOR = 16'h07E0
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        val,
    input  logic [9:0]  sync_x,
    input  logic [9:0]  sync_y,
    input  logic [4:0]  dvi_r,
    input  logic [5:0]  dvi_g,
    input  logic [4:0]  dvi_b,
    input  logic [4:0]  ccd_r,
    input  logic [5:0]  ccd_g,
    input  logic [4:0]  ccd_b,
    input  logic [4:0]  alpha,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_we,
    input  logic        sram_ack,
    output logic [3:0]  fifo_level,
    output logic        overflow,
    output logic        frame_done
);

    localparam int          c_aw     = $clog2(DEPTH);
    localparam logic [10:0] c_width  = 11'(WIDTH);
    localparam logic [10:0] c_height = 11'(HEIGHT);
    localparam logic [9:0]  c_x_last = 10'(WIDTH - 1);
    localparam logic [9:0]  c_y_last = 10'(HEIGHT - 1);
    localparam logic [19:0] c_stride = 20'(WIDTH);
    localparam logic [3:0]  c_depth  = 4'(DEPTH);
`ifdef CHROMA_KEY_EN
    localparam logic        c_key_en = 1'b1;
`else
    localparam logic        c_key_en = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // ---------------- stage 1: weights and products ----------------
    logic       w_key;
    logic [4:0] w_a;
    logic [4:0] w_ia;
    logic       w_in_range;

    // With the key disabled the compare is gated by a constant and folds away.
    assign w_key      = c_key_en & ({ccd_r, ccd_g, ccd_b} == KEY_COLOR);
    assign w_a        = w_key ? 5'd0 : ((alpha > 5'd16) ? 5'd16 : alpha);
    assign w_ia       = 5'd16 - w_a;
    assign w_in_range = ({1'b0, sync_x} < c_width) && ({1'b0, sync_y} < c_height);

    logic        r_s1_valid;
    logic [9:0]  r_s1_x, r_s1_y;
    logic [9:0]  r_pcr, r_pdr, r_pcb, r_pdb;
    logic [10:0] r_pcg, r_pdg;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_pcr      <= '0;
            r_pdr      <= '0;
            r_pcg      <= '0;
            r_pdg      <= '0;
            r_pcb      <= '0;
            r_pdb      <= '0;
        end else begin
            r_s1_valid <= val && w_in_range;
            if (val) begin
                r_s1_x <= sync_x;
                r_s1_y <= sync_y;
                r_pcr  <= {5'd0, ccd_r} * {5'd0, w_a};
                r_pdr  <= {5'd0, dvi_r} * {5'd0, w_ia};
                r_pcg  <= {5'd0, ccd_g} * {6'd0, w_a};
                r_pdg  <= {5'd0, dvi_g} * {6'd0, w_ia};
                r_pcb  <= {5'd0, ccd_b} * {5'd0, w_a};
                r_pdb  <= {5'd0, dvi_b} * {5'd0, w_ia};
            end
        end
    end

    // ---------------- stage 2: blend, address, last flag ----------------
    logic [9:0]  w_sum_r, w_sum_b;
    logic [10:0] w_sum_g;
    logic [15:0] w_data;
    logic [19:0] w_addr;
    logic        w_last;

    // Weights sum to 16, so each sum stays within 16x channel max.
    assign w_sum_r = r_pcr + r_pdr;
    assign w_sum_g = r_pcg + r_pdg;
    assign w_sum_b = r_pcb + r_pdb;
    assign w_data  = {w_sum_r[8:4], w_sum_g[9:4], w_sum_b[8:4]};
    assign w_last  = (r_s1_x == c_x_last) && (r_s1_y == c_y_last);

    generate
        if (WIDTH == 640) begin : g_addr_shift
            assign w_addr = {1'b0, r_s1_y, 9'd0} + {3'd0, r_s1_y, 7'd0} + {10'd0, r_s1_x};
        end else begin : g_addr_mult
            assign w_addr = ({10'd0, r_s1_y} * c_stride) + {10'd0, r_s1_x};
        end
    endgenerate

    logic        r_s2_valid;
    logic [36:0] r_s2_entry;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_entry <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_entry <= {w_last, w_addr, w_data};
        end
    end

    // ---------------- FIFO ----------------
    logic [36:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [3:0]      r_count;
    logic            r_overflow;
    logic            w_full, w_empty, w_push_ok, w_pop;
    logic [36:0]     w_rd_entry;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == 4'd0);
    assign w_push_ok  = r_s2_valid && !w_full;
    assign w_rd_entry = r_mem[r_rd_ptr];

    always_ff @(posedge clk_25) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= r_s2_entry;
    end

    // Full is judged before the same-edge pop, so a push into a full FIFO is lost.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {3'd0, w_push_ok} - {3'd0, w_pop};
            if (r_s2_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    // ---------------- write FSM ----------------
    state_t      r_state, w_state_nxt;
    logic        w_load, w_we_clr;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we, r_last, r_frame_done;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_we_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sram_ack) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_we_clr    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_WRITE) && sram_ack && r_last;
            if (w_load) begin
                r_last  <= w_rd_entry[36];
                r_addr  <= w_rd_entry[35:16];
                r_wdata <= w_rd_entry[15:0];
                r_we    <= 1'b1;
            end else if (w_we_clr) begin
                r_we <= 1'b0;
            end
        end
    end

    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_we    = r_we;
    assign fifo_level = r_count;
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_blend_frame_writer.sv
// ============================================================================
//  Module      : tb_blend_frame_writer
//  Description : Directed self-checking bench for blend_frame_writer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_blend_frame_writer;

    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic        val;
    logic [9:0]  sync_x, sync_y;
    logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b;
    logic [5:0]  dvi_g, ccd_g;
    logic [4:0]  alpha;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we;
    logic        sram_ack;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] wr_q [$];

    always #20 clk_25 = ~clk_25;

    blend_frame_writer dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .val        (val),
        .sync_x     (sync_x),
        .sync_y     (sync_y),
        .dvi_r      (dvi_r),
        .dvi_g      (dvi_g),
        .dvi_b      (dvi_b),
        .ccd_r      (ccd_r),
        .ccd_g      (ccd_g),
        .ccd_b      (ccd_b),
        .alpha      (alpha),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_ack   (sram_ack),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    // Inputs change 2ns after the rising edge, so at the falling edge the
    // request/ack pair shown is the one the next rising edge accepts.
    always @(negedge clk_25) begin
        if (rst_n && sram_we && sram_ack)
            wr_q.push_back({sram_addr, sram_wdata});
    end

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25);
        #2;
    endtask

    task automatic drive_pix(input int x, input int y, input logic [15:0] ccd,
                             input logic [15:0] dvi, input int al);
        val    = 1'b1;
        sync_x = 10'(x);
        sync_y = 10'(y);
        {ccd_r, ccd_g, ccd_b} = ccd;
        {dvi_r, dvi_g, dvi_b} = dvi;
        alpha  = 5'(al);
    endtask

    task automatic send_pix(input int x, input int y, input logic [15:0] ccd,
                            input logic [15:0] dvi, input int al);
        drive_pix(x, y, ccd, dvi, al);
        tick(1);
        val = 1'b0;
    endtask

    function automatic logic [35:0] q_at(input int i);
        if (i < wr_q.size())
            return wr_q[i];
        return '1;
    endfunction

    task automatic run_one(input string tag, input int x, input int y,
                           input logic [15:0] ccd, input logic [15:0] dvi, input int al,
                           input logic [19:0] exp_addr, input logic [15:0] exp_data);
        wr_q.delete();
        send_pix(x, y, ccd, dvi, al);
        tick(6);
        check_eq({tag, "_count"}, 36'(wr_q.size()), 36'd1);
        check_eq({tag, "_write"}, q_at(0), {exp_addr, exp_data});
    endtask

    initial begin
        rst_n    = 1'b0;
        sram_ack = 1'b1;
        val      = 1'b0;
        sync_x   = '0;
        sync_y   = '0;
        {ccd_r, ccd_g, ccd_b} = 16'h0;
        {dvi_r, dvi_g, dvi_b} = 16'h0;
        alpha    = '0;
        tick(2);
        check_eq("rst_addr",  36'(sram_addr),  36'd0);
        check_eq("rst_wdata", 36'(sram_wdata), 36'd0);
        check_eq("rst_we",    36'(sram_we),    36'd0);
        check_eq("rst_level", 36'(fifo_level), 36'd0);
        check_eq("rst_ovf",   36'(overflow),   36'd0);
        check_eq("rst_fdone", 36'(frame_done), 36'd0);
        rst_n = 1'b1;
        tick(2);

        // Full camera weight, latency and single-cycle write strobe
        wr_q.delete();
        send_pix(5, 2, 16'hFFFF, 16'h0000, 16);
        tick(1);
        check_eq("lat_we_n1", 36'(sram_we), 36'd0);
        tick(1);
        check_eq("lat_we_n2", 36'(sram_we), 36'd0);
        tick(1);
        check_eq("lat_we_n3", 36'(sram_we), 36'd1);
        check_eq("full_addr", 36'(sram_addr), 36'd1285);
        check_eq("full_data", 36'(sram_wdata), 36'hFFFF);
        tick(1);
        check_eq("full_we_drop", 36'(sram_we), 36'd0);
        check_eq("full_no_fdone", 36'(frame_done), 36'd0);
        check_eq("full_count", 36'(wr_q.size()), 36'd1);
        tick(2);

        run_one("half",   10, 1, 16'hFFFF, 16'h0000, 8,  20'd650, 16'h7BEF);
        run_one("clamp",   7, 0, 16'hFFFF, 16'h0000, 20, 20'd7,   16'hFFFF);
        run_one("mix",     0, 0, 16'hFFFF, 16'h8410, 4,  20'd0,   16'h9CF3);
        run_one("dvi",   639, 0, 16'hFFFF, 16'h1234, 0,  20'd639, 16'h1234);
`ifdef CHROMA_KEY_EN
        run_one("chroma",  1, 1, 16'h07E0, 16'h1234, 16, 20'd641, 16'h1234);
`else
        run_one("chroma",  1, 1, 16'h07E0, 16'h1234, 16, 20'd641, 16'h07E0);
`endif

        // Out-of-range coordinates are dropped silently
        wr_q.delete();
        send_pix(640, 0, 16'hFFFF, 16'h0000, 16);
        send_pix(0, 480, 16'hFFFF, 16'h0000, 16);
        tick(8);
        check_eq("range_count", 36'(wr_q.size()), 36'd0);
        check_eq("range_ovf",   36'(overflow),     36'd0);

        // Last pixel of the frame
        wr_q.delete();
        send_pix(639, 479, 16'hFFFF, 16'h0000, 16);
        tick(3);
        check_eq("last_we",    36'(sram_we),    36'd1);
        check_eq("last_addr",  36'(sram_addr),  36'd307199);
        check_eq("last_fd_n3", 36'(frame_done), 36'd0);
        tick(1);
        check_eq("last_fd_n4", 36'(frame_done), 36'd1);
        tick(1);
        check_eq("last_fd_n5", 36'(frame_done), 36'd0);
        tick(2);

        // Back-pressure: 12 pixels while the SRAM stalls
        sram_ack = 1'b0;
        wr_q.delete();
        for (int i = 1; i <= 12; i++) begin
            drive_pix(i, 3, 16'h0000, 16'(i), 0);
            tick(1);
        end
        val = 1'b0;
        tick(6);
        check_eq("bp_level", 36'(fifo_level), 36'd8);
        check_eq("bp_ovf",   36'(overflow),   36'd1);
        check_eq("bp_we",    36'(sram_we),    36'd1);
        check_eq("bp_addr",  36'(sram_addr),  36'd1921);
        tick(2);
        check_eq("bp_level_hold", 36'(fifo_level), 36'd8);
        sram_ack = 1'b1;
        tick(16);
        check_eq("bp_count", 36'(wr_q.size()), 36'd9);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("bp_write%0d", i + 1), q_at(i), {20'(1921 + i), 16'(i + 1)});
        check_eq("bp_ovf_sticky", 36'(overflow),   36'd1);
        check_eq("bp_level_end",  36'(fifo_level), 36'd0);

        // Reset while stalled with data buffered
        sram_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_pix(20 + i, 4, 16'hFFFF, 16'h0000, 16);
            tick(1);
        end
        val = 1'b0;
        tick(6);
        check_eq("mid_level", 36'(fifo_level), 36'd5);
        check_eq("mid_we",    36'(sram_we),    36'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we",    36'(sram_we),    36'd0);
        check_eq("mid_rst_level", 36'(fifo_level), 36'd0);
        check_eq("mid_rst_ovf",   36'(overflow),   36'd0);
        tick(2);
        rst_n    = 1'b1;
        sram_ack = 1'b1;
        wr_q.delete();
        tick(10);
        check_eq("post_rst_idle", 36'(wr_q.size()), 36'd0);
        run_one("post_rst", 3, 3, 16'hFFFF, 16'h0000, 16, 20'd1923, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/blend_frame_writer.md
Name: blend_frame_writer

Overview:
- Downstream consumer of the sync controller's output stream: val, sync_x/sync_y, dvi_* (RGB565 warped-source pixel) and ccd_* (RGB565 camera pixel).
- Alpha-blends each pixel pair and packs the result to RGB565.
- Buffers results in a small FIFO and writes them to the frame-buffer SRAM at address y*WIDTH+x, using a req/ack write handshake.
- Flags overflow and end of frame.

Parameters:
- WIDTH, 640, active pixels per line; also the address stride.
- HEIGHT, 480, active lines per frame.
- DEPTH, 8, FIFO entries (power of two, ≥2).
- KEY_COLOR, 16'h07E0, RGB565 chroma-key value (used only with CHROMA_KEY_EN).

Ports:
- clk_25  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- val  in  1  pixel valid, one cycle per pixel.
- sync_x  in  10  pixel column.
- sync_y  in  10  pixel row.
- dvi_r/dvi_g/dvi_b  in  5/6/5  warped-source pixel.
- ccd_r/ccd_g/ccd_b  in  5/6/5  camera pixel.
- alpha  in  5  camera weight 0..16; values above 16 are treated as 16.
- sram_addr  out  20  write address.
- sram_wdata  out  16  RGB565 {r,g,b}.
- sram_we  out  1  write request.
- sram_ack  in  1  write accepted this cycle.
- fifo_level  out  4  current FIFO occupancy.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0: sram_addr, sram_wdata, sram_we, fifo_level, overflow, frame_done.
  - FIFO is emptied, pipeline valids cleared, FSM forced to IDLE.
  - Reset mid-write abandons the transaction with no ack required.
- Stage 1, on the edge where val=1:
  - Register a=min(alpha,16), ia=16-a.
  - Register per-channel products ccd*a and dvi*ia (r/b 10-bit, g 11-bit).
  - Register x, y, and a valid bit.
- Coordinate filter:
  - If sync_x≥WIDTH or sync_y≥HEIGHT, the stage-1 valid is cleared and the pixel is silently dropped.
  - A dropped out-of-range pixel does not set overflow.
- Stage 2 blend:
  - Per channel: (ccd*a + dvi*ia) >> 4, truncated. No rounding; the result never exceeds channel max.
  - Address = y*WIDTH + x, computed as (y<<9)+(y<<7)+x when WIDTH=640 (generic multiply otherwise).
  - last = (x==WIDTH-1 && y==HEIGHT-1).
  - Push {last, addr, data} into the FIFO.
- Pipeline: never stalls; val to FIFO write is 2 cycles.
- FIFO:
  - Full is evaluated before the same-cycle pop. A push while full is dropped and sets overflow, even if a pop occurs that cycle.
  - fifo_level reflects the post-edge occupancy.
- Write FSM, IDLE:
  - If the FIFO is non-empty: pop, load sram_addr/sram_wdata, set sram_we=1, go to WRITE.
- Write FSM, WRITE:
  - Hold sram_we, addr and data stable until sram_ack=1.
  - On ack with the FIFO non-empty: pop the next entry back-to-back and stay in WRITE.
  - On ack with the FIFO empty: clear sram_we and go to IDLE.
  - On ack of an entry with last=1: frame_done=1 for the following cycle only.
- sram_ack is ignored while sram_we=0.
- Latency: val sampled at edge N gives sram_we high after edge N+3 (FIFO empty, FSM idle).
- Throughput: 1 pixel/cycle when sram_ack is held high.

Optional Feature:
- Macro: CHROMA_KEY_EN.
- Defined: if {ccd_r,ccd_g,ccd_b}==KEY_COLOR, stage 1 forces a=0, so the output equals the dvi pixel regardless of alpha.
- Undefined: the comparator is absent and all pixels are blended with alpha.

Test Plan:
- Full-camera blend:
  - Stimulus: alpha=16, ccd=(31,63,31), dvi=(0,0,0), x=5, y=2, sram_ack tied high.
  - Response: sram_addr=1285, sram_wdata=16'hFFFF; sram_we rises after the 3rd edge past val and drops one cycle later.
- Half blend:
  - Stimulus: alpha=8, ccd=(31,63,31), dvi=(0,0,0).
  - Response: wdata={5'd15,6'd31,5'd15}=16'h7BEF.
  - Stimulus: alpha=20.
  - Response: same as alpha=16.
- Back-pressure:
  - Stimulus: sram_ack=0 while 12 consecutive valid pixels are sent, then ack=1.
  - Response: exactly pixels 1..9 are written in order, overflow=1 and stays 1, fifo_level peaks at 8.
- Range and frame end:
  - Stimulus: pixel x=640, y=0.
  - Response: no write, overflow unchanged.
  - Stimulus: pixel x=639, y=479.
  - Response: addr=307199; frame_done pulses exactly one cycle after its ack.
- Reset mid-stall:
  - Stimulus: rst_n low while sram_we=1 and the FIFO holds 5 entries.
  - Response: sram_we=0 and fifo_level=0 immediately; no writes occur after release until a new val.
- CHROMA_KEY_EN:
  - Stimulus: ccd=16'h07E0, dvi=16'h1234, alpha=16.
  - Response: wdata=16'h1234. Without the macro: wdata=16'h07E0.
